// File: rtl/run_length_detector.sv
// Serial run-length detector: flags runs of RUN_LEN equal sampled bits on w,
// with per-symbol enables, overlapping/non-overlapping modes and a detection counter.
module run_length_detector #(
  parameter int RUN_LEN = 4,
  parameter int HIT_W   = 8,
  localparam int CNT_W  = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             w,
  input  logic [1:0]       mode,
  input  logic             overlap,
  input  logic             clr,
  output logic             z,
  output logic             z_sym,
  output logic [CNT_W-1:0] run_cnt,
  output logic [HIT_W-1:0] hit_cnt
);

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
  localparam logic [HIT_W-1:0] HIT_MAX = {HIT_W{1'b1}};

  logic             last_sym_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             sym_en_s;
  logic             detect_s;

  function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] v);
    if (v == HIT_MAX) begin
      return HIT_MAX;
    end else begin
      return v + HIT_W'(1);
    end
  endfunction

  // Run length after the current sample and whether it completes a detectable run
  always_comb begin
    cnt_next_s = CNT_W'(1);
    sym_en_s   = 1'b0;
    detect_s   = 1'b0;
    if ((run_cnt == {CNT_W{1'b0}}) || (w != last_sym_r)) begin
      cnt_next_s = CNT_W'(1);
    end else if (run_cnt == RUN_MAX) begin
      cnt_next_s = RUN_MAX;
    end else begin
      cnt_next_s = run_cnt + CNT_W'(1);
    end
    if (w) begin
      sym_en_s = mode[1];
    end else begin
      sym_en_s = mode[0];
    end
    detect_s = (cnt_next_s == RUN_MAX) && sym_en_s;
  end

  // Run tracking, detection pulse and hit counter; clr outranks en
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_sym_r <= 1'b0;
      run_cnt    <= {CNT_W{1'b0}};
      hit_cnt    <= {HIT_W{1'b0}};
      z          <= 1'b0;
      z_sym      <= 1'b0;
    end else if (clr) begin
      last_sym_r <= 1'b0;
      run_cnt    <= {CNT_W{1'b0}};
      hit_cnt    <= {HIT_W{1'b0}};
      z          <= 1'b0;
      z_sym      <= 1'b0;
    end else if (en) begin
      last_sym_r <= w;
      z          <= detect_s;
      // Non-overlapping mode restarts counting from scratch after a hit
      if (detect_s && !overlap) begin
        run_cnt <= {CNT_W{1'b0}};
      end else begin
        run_cnt <= cnt_next_s;
      end
      if (detect_s) begin
        z_sym   <= w;
        hit_cnt <= sat_inc(hit_cnt);
      end else begin
        z_sym   <= z_sym;
        hit_cnt <= hit_cnt;
      end
    end else begin
      z <= 1'b0;
    end
  end

endmodule

// File: tb/tb_run_length_detector.sv
// Scoreboard bench for run_length_detector: directed vectors push expected
// outputs; a monitor pops and compares after each sampling edge.
module tb_run_length_detector;

  typedef struct packed {
    logic       z;
    logic       zs;
    logic [2:0] run;
    logic [7:0] hit;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       w = 1'b0;
  logic [1:0] mode = 2'b11;
  logic       overlap = 1'b0;
  logic       clr = 1'b0;
  logic       z, z_sym;
  logic [2:0] run_cnt;
  logic [7:0] hit_cnt;
  logic       z2, z_sym2;
  logic [2:0] run_cnt2;
  logic [1:0] hit_cnt2;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  run_length_detector #(.RUN_LEN(4), .HIT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode), .overlap(overlap),
    .clr(clr), .z(z), .z_sym(z_sym), .run_cnt(run_cnt), .hit_cnt(hit_cnt)
  );

  run_length_detector #(.RUN_LEN(4), .HIT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode), .overlap(overlap),
    .clr(clr), .z(z2), .z_sym(z_sym2), .run_cnt(run_cnt2), .hit_cnt(hit_cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called one unit after a rising edge: drive a vector, then wait for its edge
  task automatic apply(input logic a_en, input logic a_w, input logic [1:0] a_mode,
                       input logic a_ov, input logic a_clr, input logic e_z,
                       input logic e_zs, input int e_run, input int e_hit);
    exp_t e;
    en = a_en; w = a_w; mode = a_mode; overlap = a_ov; clr = a_clr;
    e.z = e_z; e.zs = e_zs; e.run = 3'(e_run); e.hit = 8'(e_hit);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare outputs shortly after each edge that has an expectation
  initial begin
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        #2;
        check("z", int'(z), int'(mon_e.z));
        check("z_sym", int'(z_sym), int'(mon_e.zs));
        check("run_cnt", int'(run_cnt), int'(mon_e.run));
        check("hit_cnt", int'(hit_cnt), int'(mon_e.hit));
        check("hit_cnt_w2", int'(hit_cnt2), (mon_e.hit > 8'd3) ? 3 : int'(mon_e.hit));
      end
    end
  end

  initial begin
    #3;
    check("rst_z", int'(z), 0);
    check("rst_run", int'(run_cnt), 0);
    check("rst_hit", int'(hit_cnt), 0);
    #4 reset = 1'b1;
    @(posedge clk);
    #1;

    // Four zeros, non-overlapping
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1);
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1);
    apply(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

    // Overlapping run of eight ones: five hits, narrow counter saturates at 3
    apply(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
    apply(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
    apply(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
    apply(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 4, 1);
    apply(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 4, 2);
    apply(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 4, 3);
    apply(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 4, 4);
    apply(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 4, 5);
    apply(1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 4, 5);
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

    // Broken runs 1,1,0,0,0,1
    apply(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    apply(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
    apply(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

    // Only 0-runs enabled: ones saturate silently, zeros detect
    for (int i = 1; i <= 5; i++) begin
      apply(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, (i > 4) ? 4 : i, 0);
    end
    apply(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    apply(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
    apply(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
    apply(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1);

    // Mode change mid-run: saturated disabled run detects once enabled
    for (int i = 1; i <= 4; i++) begin
      apply(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, i, 1);
    end
    apply(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 4, 2);
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

    // Zeros with intermittent enable
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    apply(1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
    apply(1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1);
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

    // Reset mid-run discards progress
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
    en = 1'b0;
    #3 reset = 1'b0;
    #1;
    check("async_rst_run", int'(run_cnt), 0);
    check("async_rst_z", int'(z), 0);
    check("async_rst_zsym", int'(z_sym), 0);
    check("async_rst_hit", int'(hit_cnt), 0);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1);
    apply(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1);
    en = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    #5;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/run_length_detector.md
RUN_LENGTH_DETECTOR -- requirements
Module: run_length_detector

Interface
REQ-001 Parameter RUN_LEN, default 4, run length to detect; legal range 2..16.
REQ-002 Parameter HIT_W, default 8, width of detection counter.
REQ-003 Localparam CNT_W = $clog2(RUN_LEN+1), width of run counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 en  input  1  sample enable; w sampled only on edges where en=1.
REQ-007 w  input  1  serial data bit.
REQ-008 mode  input  2  bit0=1 enables detection of 0-runs, bit1=1 enables detection of 1-runs.
REQ-009 overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 clr  input  1  synchronous clear of counters and output.
REQ-011 z  output  1  registered detection pulse.
REQ-012 z_sym  output  1  symbol of the most recently detected run.
REQ-013 run_cnt  output  CNT_W  current length of the run of equal sampled bits.
REQ-014 hit_cnt  output  HIT_W  number of detections since reset/clr.

Function
REQ-015 Internal last_sym register holds the symbol of the current run.
REQ-016 Sampled edge (en=1, clr=0) with run_cnt=0 or w!=last_sym: run_cnt<=1, last_sym<=w.
REQ-017 Sampled edge with run_cnt>0 and w==last_sym: run_cnt<=min(run_cnt+1, RUN_LEN).
REQ-018 Detection event = sampled edge where updated run_cnt value equals RUN_LEN and mode bit for w is 1.
REQ-019 On detection: z<=1, z_sym<=w, hit_cnt<=hit_cnt+1, saturating at 2^HIT_W-1.
REQ-020 overlap=1: run_cnt stays at RUN_LEN; each further equal sample is a new detection.
REQ-021 overlap=0: on detection run_cnt<=0 (overrides REQ-017); next sample starts a fresh run at 1.
REQ-022 Run of a disabled symbol: run_cnt counts and saturates at RUN_LEN; z stays 0; hit_cnt unchanged.
REQ-023 Latency: z high in the cycle immediately after the edge that sampled the RUN_LEN-th equal bit; z is high exactly one cycle per detection.
REQ-024 Edge without detection (including en=0): z<=0; z_sym holds.
REQ-025 en=0: run_cnt, last_sym, hit_cnt, z_sym hold; a run continues across disabled cycles.
REQ-026 mode/overlap changes take effect on the next sampled edge; run_cnt is not reset by a change.
REQ-027 clr=1 at an edge: run_cnt<=0, hit_cnt<=0, z<=0, z_sym<=0, last_sym<=0; clr has priority over en.

Reset
REQ-028 reset=0 asynchronously forces z=0, z_sym=0, run_cnt=0, hit_cnt=0, last_sym=0, independent of clk.
REQ-029 Reset asserted mid-run discards run progress; after release a full RUN_LEN fresh run is required for detection.
REQ-030 First sampled edge after reset release follows REQ-016.

Verification (RUN_LEN=4, HIT_W=8 unless stated)
REQ-031 mode=11, overlap=0, en=1, w=0,0,0,0 -> z=1 for one cycle after 4th edge, z_sym=0, hit_cnt=1, run_cnt=0.
REQ-032 mode=11, overlap=1, w=1 for 6 edges -> z=1 after edges 4,5,6; hit_cnt=3; run_cnt=4; z_sym=1.
REQ-033 w=1,1,0,0,0,1 -> z never asserted; run_cnt ends at 1; hit_cnt=0.
REQ-034 mode=01, w=1,1,1,1,1 -> z=0 throughout; run_cnt=4; then w=0,0,0,0 -> single z pulse, z_sym=0.
REQ-035 w=0 held with en=1,0,1,0,1,1 -> z asserted only after 4th enabled edge; run_cnt holds across en=0.
REQ-036 Three w=0 samples, reset pulsed low mid-cycle -> all outputs 0 immediately; one more 0 gives no z; four more 0s give z; HIT_W=2 with 5 detections -> hit_cnt=3.
